pipelined_write_arb: RTL and testbench
======================================

PIPELINED_WRITE_ARB -- requirements
Module: pipelined_write_arb

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters (2..8).
REQ-002 Parameter MAX_WR_CYCLES, default 4, max data beats per write.
REQ-003 Parameter WR_WIDTH, default 8, data bits per beat.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_vld  input  NUM_REQ  requester i holds a complete write.
REQ-007 req_rdy  output  NUM_REQ  one-cycle capture pulse to granted requester.
REQ-008 req_cmd  input  NUM_REQ*10  per-requester write_cmd_t {vld[9], rsvd[8:5], num_cycles[4:3], write_type[2:0]}.
REQ-009 req_dat  input  NUM_REQ*MAX_WR_CYCLES*WR_WIDTH  per-requester data; beat k at bits [k*WR_WIDTH +: WR_WIDTH].
REQ-010 bus_vld  output  1  bus beat valid.
REQ-011 bus_rdy  input  1  downstream accepts beat; transfer = bus_vld & bus_rdy.
REQ-012 bus_dat  output  WR_WIDTH+2  cmd beat (write_cmd_t, zero-extended) or data beat write_data_t {cycle_type[WR_WIDTH+1:WR_WIDTH], dat}.
REQ-013 wdone  output  NUM_REQ  one-cycle completion pulses to owner.
REQ-014 err_type  output  1  one-cycle pulse: captured write_type > 2.

Function
REQ-015 FSM states IDLE, CMD, DATA; reset state IDLE.
REQ-016 IDLE: if any req_vld, grant per round-robin, pulse req_rdy[grant], capture req_cmd/req_dat of grant into local registers, go CMD; else stay.
REQ-017 Round-robin: search starts at index (last_grant+1) mod NUM_REQ; last_grant reset = NUM_REQ-1 so requester 0 wins first.
REQ-018 Grant locks for whole transaction; req_vld changes after capture are ignored until return to IDLE.
REQ-019 Beat count N = num_cycles when nonzero, else MAX_WR_CYCLES.
REQ-020 CMD: bus_vld=1, bus_dat = captured cmd with vld forced 1 and rsvd forced 0; on transfer go DATA, beat counter = 0.
REQ-021 DATA: bus_vld=1, bus_dat.dat = beat[counter]; cycle_type = VALID(1) for counter<N-1, DONE(2) for counter=N-1.
REQ-022 On each DATA transfer counter increments; on transfer of beat N-1 go IDLE.
REQ-023 bus_vld low -> bus_dat = 0 (cycle_type IDLE=0).
REQ-024 While bus_rdy=0 bus_vld and bus_dat hold stable; no state change.
REQ-025 WRITE_TYPE_STD(0): no wdone pulses.
REQ-026 WRITE_TYPE_MULTI_WDONE(1): wdone[owner] pulses the cycle after each data transfer (N pulses).
REQ-027 WRITE_TYPE_SINGLE_WDONE(2): wdone[owner] pulses once, cycle after beat N-1 transfer.
REQ-028 write_type 3..7: err_type pulses cycle after capture; transaction proceeds as STD with type field sent unmodified.
REQ-029 Minimum occupancy: 1 IDLE/grant cycle + 1 cmd + N data; next grant earliest the cycle after last beat transfer.
REQ-030 req_vld with no grant pending never asserts req_rdy; at most one req_rdy bit high per cycle.
REQ-031 bus_dat and bus_vld driven from registers (no combinational path from req_* or bus_rdy to bus_*).

Reset
REQ-032 rst_n low asynchronously forces: state IDLE, bus_vld=0, bus_dat=0, req_rdy=0, wdone=0, err_type=0, counter=0, last_grant=NUM_REQ-1.
REQ-033 Reset mid-transaction aborts it; no wdone issued for aborted write; first grant after release follows REQ-017.

Verification
REQ-034 Req0 cmd num_cycles=2, type=STD, dat beats 0x11,0x22, bus_rdy=1 -> bus: cmd 0x210 (vld=1,num=2,type=0), {1,0x11}, {2,0x22}; no wdone.
REQ-035 Req1 num_cycles=0, type=MULTI, bus_rdy=1 -> 1 cmd + 4 data beats, last cycle_type=DONE; wdone[1] pulses 4 times.
REQ-036 Req0 and Req1 both valid continuously, type=SINGLE, N=1 -> grants alternate 0,1,0,1; one wdone per write to correct owner.
REQ-037 bus_rdy toggles 0/1 every cycle during 3-beat write -> bus_dat stable while stalled, beats in order, no loss/duplication.
REQ-038 type=5 captured -> err_type pulse once, write completes, no wdone.
REQ-039 rst_n asserted during DATA beat 2 of 4 -> all outputs 0 immediately; no wdone; after release req0 wins first.

Source files
------------

// File: rtl/pipelined_write_arb.sv
// Round-robin arbiter that captures one requester's complete write, then streams
// it to a single bus as a command beat followed by N data beats.
module pipelined_write_arb #(
  parameter int NUM_REQ       = 2,
  parameter int MAX_WR_CYCLES = 4,
  parameter int WR_WIDTH      = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_REQ-1:0]                    req_vld,
  output logic [NUM_REQ-1:0]                    req_rdy,
  input  logic [NUM_REQ*10-1:0]                 req_cmd,
  input  logic [NUM_REQ*MAX_WR_CYCLES*WR_WIDTH-1:0] req_dat,
  output logic                                  bus_vld,
  input  logic                                  bus_rdy,
  output logic [WR_WIDTH+1:0]                   bus_dat,
  output logic [NUM_REQ-1:0]                    wdone,
  output logic                                  err_type
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (MAX_WR_CYCLES > 1) ? $clog2(MAX_WR_CYCLES) : 1;
  localparam int DW = MAX_WR_CYCLES * WR_WIDTH;
  localparam int BW = WR_WIDTH + 2;

  localparam logic [1:0] CT_VALID   = 2'd1;
  localparam logic [1:0] CT_DONE    = 2'd2;
  localparam logic [2:0] WT_MULTI   = 3'd1;
  localparam logic [2:0] WT_SINGLE  = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t              state_r;
  logic [GW-1:0]       last_grant_r;
  logic [4:0]          cmd_r;
  logic [DW-1:0]       data_r;
  logic [CW-1:0]       cnt_r;
  logic                bus_vld_r;
  logic [BW-1:0]       bus_dat_r;
  logic [NUM_REQ-1:0]  req_rdy_r;
  logic [NUM_REQ-1:0]  wdone_r;
  logic                err_type_r;

  logic [GW-1:0]       grant_s;
  logic                found_s;
  logic [4:0]          cap_cmd_s;
  logic [DW-1:0]       cap_dat_s;
  logic [CW-1:0]       last_idx_s;
  logic [CW-1:0]       nxt_idx_s;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [GW-1:0] idx);
    onehot = NUM_REQ'(1) << idx;
  endfunction

  function automatic logic [BW-1:0] data_beat(input logic [DW-1:0] d, input int k, input logic last);
    data_beat = {(last ? CT_DONE : CT_VALID), d[k*WR_WIDTH +: WR_WIDTH]};
  endfunction

  // Round-robin search starting just after the previous winner.
  always_comb begin
    grant_s = last_grant_r;
    found_s = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found_s && req_vld[(int'(last_grant_r) + i) % NUM_REQ]) begin
        grant_s = GW'((int'(last_grant_r) + i) % NUM_REQ);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Slices of the winning requester and the index of the final data beat.
  always_comb begin
    cap_cmd_s = req_cmd[int'(grant_s)*10 +: 5];
    cap_dat_s = req_dat[int'(grant_s)*DW +: DW];
    nxt_idx_s = CW'(cnt_r + CW'(1));
    if (cmd_r[4:3] == 2'd0) begin
      last_idx_s = CW'(MAX_WR_CYCLES - 1);
    end else begin
      last_idx_s = CW'(cmd_r[4:3] - 2'd1);
    end
  end

  // Transaction FSM; every output is a register so nothing on the bus
  // depends combinationally on req_* or bus_rdy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      last_grant_r <= GW'(NUM_REQ - 1);
      cmd_r        <= 5'd0;
      data_r       <= '0;
      cnt_r        <= '0;
      bus_vld_r    <= 1'b0;
      bus_dat_r    <= '0;
      req_rdy_r    <= '0;
      wdone_r      <= '0;
      err_type_r   <= 1'b0;
    end else begin
      req_rdy_r  <= '0;
      wdone_r    <= '0;
      err_type_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            last_grant_r <= grant_s;
            cmd_r        <= cap_cmd_s;
            data_r       <= cap_dat_s;
            req_rdy_r    <= onehot(grant_s);
            err_type_r   <= (cap_cmd_s[2:0] > WT_SINGLE);
            bus_vld_r    <= 1'b1;
            bus_dat_r    <= BW'({1'b1, 4'b0000, cap_cmd_s});
            cnt_r        <= '0;
            state_r      <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (bus_rdy) begin
            bus_dat_r <= data_beat(data_r, 0, (last_idx_s == CW'(0)));
            cnt_r     <= '0;
            state_r   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bus_rdy) begin
            if ((cmd_r[2:0] == WT_MULTI) ||
                ((cmd_r[2:0] == WT_SINGLE) && (cnt_r == last_idx_s))) begin
              wdone_r <= onehot(last_grant_r);
            end
            if (cnt_r == last_idx_s) begin
              bus_vld_r <= 1'b0;
              bus_dat_r <= '0;
              cnt_r     <= '0;
              state_r   <= ST_IDLE;
            end else begin
              cnt_r     <= nxt_idx_s;
              bus_dat_r <= data_beat(data_r, int'(nxt_idx_s), (nxt_idx_s == last_idx_s));
            end
          end
        end
        default: begin
          bus_vld_r <= 1'b0;
          bus_dat_r <= '0;
          cnt_r     <= '0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_rdy  = req_rdy_r;
  assign bus_vld  = bus_vld_r;
  assign bus_dat  = bus_dat_r;
  assign wdone    = wdone_r;
  assign err_type = err_type_r;

endmodule

// File: tb/tb_pipelined_write_arb.sv
// Scoreboard bench for pipelined_write_arb: expected beats, grants and wdone
// pulses are queued when a write is issued and checked as the bus produces them.
module tb_pipelined_write_arb;

  localparam int NR = 2;
  localparam int MW = 4;
  localparam int WW = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_vld = '0;
  logic [NR-1:0]     req_rdy;
  logic [NR*10-1:0]  req_cmd = '0;
  logic [NR*MW*WW-1:0] req_dat = '0;
  logic              bus_vld;
  logic              bus_rdy = 1'b1;
  logic [WW+1:0]     bus_dat;
  logic [NR-1:0]     wdone;
  logic              err_type;

  pipelined_write_arb #(.NUM_REQ(NR), .MAX_WR_CYCLES(MW), .WR_WIDTH(WW)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_cmd(req_cmd), .req_dat(req_dat), .bus_vld(bus_vld), .bus_rdy(bus_rdy),
    .bus_dat(bus_dat), .wdone(wdone), .err_type(err_type)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [9:0] beat; logic [1:0] wd; } exp_t;
  typedef struct packed { logic [1:0] rdy; logic err; } gexp_t;

  exp_t  exp_q[$];
  gexp_t gq[$];
  exp_t  e;
  gexp_t g;

  int checks = 0;
  int fails = 0;
  int xfers = 0;
  int stalls = 0;
  int wd_cnt0 = 0;
  int wd_cnt1 = 0;
  int err_cnt = 0;
  logic [1:0] wd_pending = '0;
  logic prev_stall = 1'b0;
  logic [9:0] prev_dat = '0;
  logic toggle_rdy = 1'b0;

  // Bus/grant monitor: pops the scoreboard on every transfer and grant.
  always @(negedge clk) begin
    if (!rst_n) begin
      wd_pending = '0;
      prev_stall = 1'b0;
    end else begin
      checks++;
      if (wdone !== wd_pending) begin
        fails++;
        $display("FAIL wdone_timing: got %b expected %b at %0t", wdone, wd_pending, $time);
      end
      wd_cnt0 += int'(wdone[0]);
      wd_cnt1 += int'(wdone[1]);
      err_cnt += int'(err_type);
      if (prev_stall) begin
        checks++;
        if (bus_vld !== 1'b1 || bus_dat !== prev_dat) begin
          fails++;
          $display("FAIL stall_hold: got vld=%b dat=%h expected vld=1 dat=%h", bus_vld, bus_dat, prev_dat);
        end
      end
      if (bus_vld !== 1'b1) begin
        checks++;
        if (bus_dat !== 10'h000) begin
          fails++;
          $display("FAIL idle_dat: got %h expected 000", bus_dat);
        end
      end
      if (req_rdy !== 2'b00) begin
        if (gq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_grant: got req_rdy=%b expected none", req_rdy);
        end else begin
          g = gq.pop_front();
          checks++;
          if (req_rdy !== g.rdy || err_type !== g.err) begin
            fails++;
            $display("FAIL grant: got rdy=%b err=%b expected rdy=%b err=%b", req_rdy, err_type, g.rdy, g.err);
          end
        end
      end else begin
        checks++;
        if (err_type !== 1'b0) begin
          fails++;
          $display("FAIL err_spurious: got %b expected 0", err_type);
        end
      end
      wd_pending = '0;
      if (bus_vld === 1'b1 && bus_rdy === 1'b1) begin
        xfers++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat: got %h expected none", bus_dat);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (bus_dat !== e.beat) begin
            fails++;
            $display("FAIL bus_beat: got %h expected %h", bus_dat, e.beat);
          end
          wd_pending = e.wd;
        end
      end
      prev_stall = (bus_vld === 1'b1) && (bus_rdy !== 1'b1);
      if (prev_stall) stalls++;
      prev_dat = bus_dat;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_rdy) bus_rdy = ~bus_rdy;
  endtask

  // Reference model of one write: grant, command beat, data beats, wdone mask.
  task automatic push_write(input int r, input logic [9:0] cmd, input logic [31:0] dat);
    int n;
    logic [2:0] t;
    logic [1:0] oh;
    logic lst;
    exp_t x;
    gexp_t y;
    t = cmd[2:0];
    n = (cmd[4:3] == 2'd0) ? MW : int'(cmd[4:3]);
    oh = 2'(1) << r;
    y.rdy = oh;
    y.err = (t > 3'd2);
    gq.push_back(y);
    x.beat = {1'b1, 4'b0000, cmd[4:0]};
    x.wd = 2'b00;
    exp_q.push_back(x);
    for (int k = 0; k < n; k++) begin
      lst = (k == n - 1);
      x.beat = {(lst ? 2'd2 : 2'd1), dat[k*8 +: 8]};
      x.wd = ((t == 3'd1) || (t == 3'd2 && lst)) ? oh : 2'b00;
      exp_q.push_back(x);
    end
  endtask

  task automatic drive_req(input int r, input logic [9:0] cmd, input logic [31:0] dat);
    req_cmd[r*10 +: 10] = cmd;
    req_dat[r*32 +: 32] = dat;
    req_vld[r] = 1'b1;
  endtask

  task automatic wait_rdy(input int r);
    int cyc;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (req_rdy[r] !== 1'b1 && cyc < 50);
    checks++;
    if (req_rdy[r] !== 1'b1) begin
      fails++;
      $display("FAIL rdy_timeout: requester %0d got no req_rdy, expected one within 50 cycles", r);
    end
    req_vld[r] = 1'b0;
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || gq.size() != 0) && cyc < 300) begin
      tick();
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0 || gq.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
      exp_q.delete();
      gq.delete();
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if (bus_vld !== 1'b0 || bus_dat !== 10'h000 || req_rdy !== 2'b00 || wdone !== 2'b00 || err_type !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got vld=%b dat=%h rdy=%b wdone=%b err=%b expected all 0",
               bus_vld, bus_dat, req_rdy, wdone, err_type);
    end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_std();
    int w0, w1;
    w0 = wd_cnt0; w1 = wd_cnt1;
    push_write(0, 10'h010, 32'h0000_2211);
    drive_req(0, 10'h010, 32'h0000_2211);
    wait_rdy(0);
    wait_drain();
    checks++;
    if (wd_cnt0 != w0 || wd_cnt1 != w1) begin
      fails++;
      $display("FAIL std_no_wdone: got %0d/%0d pulses expected 0/0", wd_cnt0 - w0, wd_cnt1 - w1);
    end
  endtask

  task automatic test_multi();
    int w1;
    w1 = wd_cnt1;
    push_write(1, 10'h141, 32'hD4C3_B2A1);
    drive_req(1, 10'h141, 32'hD4C3_B2A1);
    wait_rdy(1);
    wait_drain();
    checks++;
    if (wd_cnt1 - w1 != 4) begin
      fails++;
      $display("FAIL multi_wdone: got %0d pulses expected 4", wd_cnt1 - w1);
    end
  endtask

  task automatic test_alternate();
    int w0, w1, grants, cyc;
    w0 = wd_cnt0; w1 = wd_cnt1;
    for (int i = 0; i < 2; i++) begin
      push_write(0, 10'h00A, 32'h0000_0055);
      push_write(1, 10'h00A, 32'h0000_0066);
    end
    drive_req(0, 10'h00A, 32'h0000_0055);
    drive_req(1, 10'h00A, 32'h0000_0066);
    grants = 0;
    cyc = 0;
    while (grants < 4 && cyc < 100) begin
      tick();
      cyc++;
      if (req_rdy !== 2'b00) grants++;
    end
    req_vld = '0;
    checks++;
    if (grants != 4) begin
      fails++;
      $display("FAIL alt_grants: got %0d grants expected 4", grants);
    end
    wait_drain();
    checks++;
    if (wd_cnt0 - w0 != 2 || wd_cnt1 - w1 != 2) begin
      fails++;
      $display("FAIL alt_wdone: got %0d/%0d pulses expected 2/2", wd_cnt0 - w0, wd_cnt1 - w1);
    end
  endtask

  task automatic test_stall();
    int s0;
    s0 = stalls;
    push_write(0, 10'h018, 32'h0033_2211);
    toggle_rdy = 1'b1;
    drive_req(0, 10'h018, 32'h0033_2211);
    wait_rdy(0);
    wait_drain();
    toggle_rdy = 1'b0;
    bus_rdy = 1'b1;
    checks++;
    if (stalls == s0) begin
      fails++;
      $display("FAIL stall_seen: got 0 stalled cycles expected at least 1");
    end
  endtask

  task automatic test_err();
    int e0, w0, w1;
    e0 = err_cnt; w0 = wd_cnt0; w1 = wd_cnt1;
    push_write(1, 10'h015, 32'h0000_BEEF);
    drive_req(1, 10'h015, 32'h0000_BEEF);
    wait_rdy(1);
    wait_drain();
    checks++;
    if (err_cnt - e0 != 1 || wd_cnt0 != w0 || wd_cnt1 != w1) begin
      fails++;
      $display("FAIL err_type: got %0d err pulses %0d wdone expected 1 and 0",
               err_cnt - e0, (wd_cnt0 - w0) + (wd_cnt1 - w1));
    end
  endtask

  task automatic test_reset_abort();
    int base, cyc, w0;
    w0 = wd_cnt0;
    push_write(0, 10'h002, 32'h4433_2211);
    base = xfers;
    drive_req(0, 10'h002, 32'h4433_2211);
    wait_rdy(0);
    cyc = 0;
    while (xfers < base + 3 && cyc < 50) begin
      tick();
      cyc++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_vld !== 1'b0 || bus_dat !== 10'h000 || req_rdy !== 2'b00 || wdone !== 2'b00 || err_type !== 1'b0) begin
      fails++;
      $display("FAIL abort_outputs: got vld=%b dat=%h rdy=%b wdone=%b err=%b expected all 0",
               bus_vld, bus_dat, req_rdy, wdone, err_type);
    end
    exp_q.delete();
    gq.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (wd_cnt0 != w0) begin
      fails++;
      $display("FAIL abort_wdone: got %0d pulses expected 0", wd_cnt0 - w0);
    end
    push_write(0, 10'h008, 32'h0000_0077);
    push_write(1, 10'h008, 32'h0000_0088);
    drive_req(0, 10'h008, 32'h0000_0077);
    drive_req(1, 10'h008, 32'h0000_0088);
    wait_rdy(0);
    wait_rdy(1);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_std();
    test_multi();
    test_alternate();
    test_stall();
    test_err();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
